// File: rtl/rr_op_sequencer.sv
// rr_op_sequencer: drives Datapath control for one register-register or
// register-immediate ALU operation (load, execute, write-back, RF write),
// with a bounded wait on multi-cycle ALU ops and a timeout abort path.
module rr_op_sequencer #(
    parameter int DATA_W   = 32,
    parameter int RF_AW    = 4,
    parameter int CTRL_W   = 4,
    parameter int MAX_WAIT = 16
) (
    input  logic              iClk,
    input  logic              nRst,
    input  logic              iStart,
    input  logic [CTRL_W-1:0] iOp,
    input  logic [RF_AW-1:0]  iRa,
    input  logic [RF_AW-1:0]  iRb,
    input  logic [RF_AW-1:0]  iRc,
    input  logic              iUseImm,
    input  logic [DATA_W-1:0] iImm,
    input  logic              iHiSel,
    input  logic              iALU_busy,
    output logic              oReady,
    output logic              oDone,
    output logic              oTimeout,
    output logic [RF_AW-1:0]  oRF_AddrA,
    output logic [RF_AW-1:0]  oRF_AddrB,
    output logic [RF_AW-1:0]  oRF_AddrC,
    output logic              oRF_Write,
    output logic              oRA_en,
    output logic              oRB_en,
    output logic              oRZH_en,
    output logic              oRZL_en,
    output logic              oRWB_en,
    output logic [CTRL_W-1:0] oALU_Ctrl,
    output logic              oMUX_BIS,
    output logic              oMUX_RZHS,
    output logic [DATA_W-1:0] oImm32
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WB,
        S_WRITE,
        S_ABORT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CTRL_W-1:0] r_op;
    logic [RF_AW-1:0]  r_ra;
    logic [RF_AW-1:0]  r_rb;
    logic [RF_AW-1:0]  r_rc;
    logic              r_use_imm;
    logic [DATA_W-1:0] r_imm;
    logic              r_hi_sel;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic w_accept;
    logic w_wait_expired;

    assign w_accept       = (r_state == S_IDLE) && iStart;
    assign w_wait_expired = (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command capture: only in IDLE, so later iStart pulses are ignored.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_op      <= '0;
            r_ra      <= '0;
            r_rb      <= '0;
            r_rc      <= '0;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
            r_hi_sel  <= 1'b0;
        end else if (w_accept) begin
            r_op      <= iOp;
            r_ra      <= iRa;
            r_rb      <= iRb;
            r_rc      <= iRc;
            r_use_imm <= iUseImm;
            r_imm     <= iImm;
            r_hi_sel  <= iHiSel;
        end
    end

    // Busy-wait counter: cleared in LOAD, counts busy EXEC cycles, saturates.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_EXEC) && iALU_busy &&
                     (r_wait_cnt < CNT_W'(MAX_WAIT))) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (iStart) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_EXEC;
            S_EXEC: begin
                if (!iALU_busy) begin
                    w_next_state = S_WB;
                end else if (w_wait_expired) begin
                    w_next_state = S_ABORT;
                end
            end
            S_WB:    w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_IDLE;
            S_ABORT: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: everything 0 unless the current state drives it.
    always_comb begin
        oReady    = 1'b0;
        oDone     = 1'b0;
        oTimeout  = 1'b0;
        oRF_AddrA = '0;
        oRF_AddrB = '0;
        oRF_AddrC = '0;
        oRF_Write = 1'b0;
        oRA_en    = 1'b0;
        oRB_en    = 1'b0;
        oRZH_en   = 1'b0;
        oRZL_en   = 1'b0;
        oRWB_en   = 1'b0;
        oALU_Ctrl = '0;
        oMUX_BIS  = 1'b0;
        oMUX_RZHS = 1'b0;
        oImm32    = '0;
        case (r_state)
            S_IDLE: begin
                oReady = 1'b1;
            end
            S_LOAD: begin
                oRF_AddrA = r_ra;
                oRF_AddrB = r_rb;
                oRF_AddrC = r_rc;
                oMUX_BIS  = r_use_imm;
                oImm32    = r_imm;
                oRA_en    = 1'b1;
                oRB_en    = 1'b1;
            end
            S_EXEC: begin
                oRF_AddrA = r_ra;
                oRF_AddrB = r_rb;
                oRF_AddrC = r_rc;
                oMUX_BIS  = r_use_imm;
                oImm32    = r_imm;
                oALU_Ctrl = r_op;
                // Result registers capture on the cycle the ALU is not busy.
                oRZH_en   = ~iALU_busy;
                oRZL_en   = ~iALU_busy;
            end
            S_WB: begin
                oRF_AddrA = r_ra;
                oRF_AddrB = r_rb;
                oRF_AddrC = r_rc;
                oMUX_RZHS = r_hi_sel;
                oRWB_en   = 1'b1;
            end
            S_WRITE: begin
                oRF_AddrA = r_ra;
                oRF_AddrB = r_rb;
                oRF_AddrC = r_rc;
                oRF_Write = 1'b1;
                oDone     = 1'b1;
            end
            S_ABORT: begin
                oDone    = 1'b1;
                oTimeout = 1'b1;
            end
            default: begin
                oReady = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/rr_op_sequencer.md
# rr_op_sequencer

Synthesizable micro-sequencer that drives the Datapath control inputs for one register-register or register-immediate ALU operation. It accepts a command through a start/ready handshake and steps through operand load, execute, write-back capture and register-file write. It generalises the fixed five-step AND/OR bench sequence to any ALU opcode, optional immediate B operand, hi/lo result select, and multi-cycle ALU operations with a bounded wait. It sits between the control unit's decode and the Datapath, and replaces hand-timed control for ALU-class instructions.

## Interface
- DATA_W, 32, datapath and immediate width
- RF_AW, 4, register-file address width
- CTRL_W, 4, ALU control code width
- MAX_WAIT, 16, max consecutive busy cycles tolerated in EXEC (≥1)

- iClk  in  1  clock, rising edge
- nRst  in  1  asynchronous, active-low reset
- iStart  in  1  command valid; accepted only when oReady=1
- iOp  in  CTRL_W  ALU control code
- iRa, iRb, iRc  in  RF_AW  source A, source B, destination
- iUseImm  in  1  B operand from iImm instead of iRb
- iImm  in  DATA_W  immediate value
- iHiSel  in  1  write back RZH instead of RZL
- iALU_busy  in  1  ALU multi-cycle op in progress
- oReady  out  1  idle, can accept command
- oDone  out  1  one-cycle completion pulse
- oTimeout  out  1  one-cycle pulse, coincident with oDone on abort
- oRF_AddrA, oRF_AddrB, oRF_AddrC  out  RF_AW  register-file addresses
- oRF_Write, oRA_en, oRB_en, oRZH_en, oRZL_en, oRWB_en  out  1  datapath enables
- oALU_Ctrl  out  CTRL_W  ALU operation
- oMUX_BIS  out  1  1 = immediate on ALU B
- oMUX_RZHS  out  1  1 = RZH selected to write-back
- oImm32  out  DATA_W  immediate to datapath

## Operation
- States: IDLE, LOAD, EXEC, WB, WRITE, ABORT.
- IDLE: oReady=1. On iStart=1, latch iOp, iRa, iRb, iRc, iUseImm, iImm, iHiSel; go to LOAD. Inputs are ignored in every other state, including iStart.
- LOAD: oRF_AddrA=Ra, oRF_AddrB=Rb, oMUX_BIS=UseImm, oImm32=Imm, oRA_en=oRB_en=1; go to EXEC; clear wait counter.
- EXEC: oALU_Ctrl=Op; oMUX_BIS and oImm32 held. oRZH_en=oRZL_en=~iALU_busy (combinational on input). If iALU_busy=0, go to WB. If iALU_busy=1, increment counter; when the counter reaches MAX_WAIT-1 with busy still high, go to ABORT.
- WB: oMUX_RZHS=HiSel, oRWB_en=1; go to WRITE.
- WRITE: oRF_AddrC=Rc, oRF_Write=1, oDone=1; go to IDLE.
- ABORT: oDone=1, oTimeout=1, no register-file write; go to IDLE.
- All outputs not listed for a state are 0. oALU_Ctrl is 0 outside EXEC. Addresses are held from LOAD through WRITE and are 0 in IDLE.
- Wait counter width is clog2(MAX_WAIT+1). The counter saturates and never wraps.
- Rc=Ra or Rc=Rb is legal. Operands are already captured in RA/RB before the write.

## Timing
- Reset (async assert, sync deassert at the Datapath level): state=IDLE, oReady=1, every other output 0, counter 0, latched command 0.
- Reset asserted mid-operation forces IDLE immediately. No oDone is produced and oRF_Write drops with reset.
- Latency with busy never high: accept edge E0; LOAD, EXEC, WB and WRITE occupy cycles 1–4. oDone is high in cycle 4, oReady is high in cycle 5.
- Each busy cycle in EXEC adds one cycle.
- Abort: busy held for MAX_WAIT EXEC cycles leads to ABORT in the next cycle, then IDLE.
- Back-to-back: iStart held high is accepted in the first cycle oReady=1. Throughput is one op per 5 cycles minimum.
- Exactly one oRZH_en/oRZL_en pulse, one oRWB_en pulse and one oRF_Write pulse per non-aborted command.

## Test plan
- Preload R3=0x22, R7=0x24. Command Op=OR, Ra=3, Rb=7, Rc=4, busy=0 → R4=0x26. oDone in cycle 4, oReady in cycle 5, exactly one oRF_Write with AddrC=4.
- iUseImm=1, iImm=0x0F, Ra=3 (0x22), Op=AND, Rc=5 → oMUX_BIS=1 in LOAD and EXEC, R5=0x02.
- iALU_busy high for 3 EXEC cycles → oRZL_en asserts only on the 4th EXEC cycle, oDone in cycle 7, result correct. With iHiSel=1, oMUX_RZHS=1 in WB.
- MAX_WAIT=8, busy held high → after 8 EXEC cycles, oDone=oTimeout=1 for one cycle, oRF_Write never asserted, oReady returns.
- iStart pulsed with different Rc during EXEC → ignored. The original Rc is written, followed by exactly one oDone.
- nRst low during EXEC → all outputs 0 and oReady=1 immediately. No register-file write. A new command after release completes normally.
